ascon_perm_iter: RTL and testbench

//  Iterative Ascon permutation: holds the 320-bit state in a register and applies one round per clock.

---
 rtl/ascon_pack.sv | 40 ++++
 rtl/ascon_perm_iter_round_counter.sv | 36 +++
 rtl/ascon_round.sv | 65 ++++++
 rtl/ascon_perm_iter.sv | 85 ++++++++
 tb/tb_ascon_perm_iter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the iterative Ascon permutation.
package ascon_pack;

   // Five 64-bit words; x0 is the most significant word, so that
   // {x0, x1, x2, x3, x4} maps directly onto the flat 320-bit view.
   typedef logic [4:0][63:0] type_state;

   localparam int X0 = 4;
   localparam int X1 = 3;
   localparam int X2 = 2;
   localparam int X3 = 1;
   localparam int X4 = 0;

   localparam int         NUM_ROUNDS = 12;
   localparam logic [3:0] LAST_ROUND = 4'd11;

   // Round constants added to x2, indexed by the absolute round number.
   localparam logic [7:0] ROUND_CST [0:11] = '{
      8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
      8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
   };

   // Linear-layer rotation amounts, indexed by word number x0..x4.
   localparam int ROT_A [0:4] = '{19, 61, 1, 10, 7};
   localparam int ROT_B [0:4] = '{28, 39, 6, 17, 41};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } type_perm_fsm;

   // 64-bit rotate right.
   function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction

endpackage

// File: rtl/ascon_perm_iter_round_counter.sv
// Round index register: loadable start value, saturating increment, last-round flag.
module round_counter
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       inc_i,
   output logic [3:0] round_o,
   output logic       last_o
);
   logic [3:0] round_q, round_d;

   // Load wins over increment; the index stops at the last round and never wraps.
   always_comb begin
      round_d = round_q;
      if (load_i) begin
         round_d = load_val_i;
      end else if (inc_i && (round_q != LAST_ROUND)) begin
         round_d = round_q + 4'd1;
      end
   end

   // Round index register.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         round_q <= 4'd0;
      end else begin
         round_q <= round_d;
      end
   end

   assign round_o = round_q;
   assign last_o  = (round_q == LAST_ROUND);
endmodule

// File: rtl/ascon_round.sv
// Ascon round layers: constant addition (pc), S-box layer (ps), linear diffusion (pl).

module pc
   import ascon_pack::*;
(
   input  type_state  state_i,
   input  logic [3:0] round_i,
   output type_state  state_o
);
   logic [7:0] cst;

   // XOR the round constant into the low byte of x2.
   always_comb begin
      cst = 8'h00;
      if (round_i <= LAST_ROUND) begin
         cst = ROUND_CST[round_i];
      end
      state_o     = state_i;
      state_o[X2] = state_i[X2] ^ {56'h0, cst};
   end
endmodule

module ps
   import ascon_pack::*;
(
   input  type_state state_i,
   output type_state state_o
);
   logic [63:0] a0, a1, a2, a3, a4;
   logic [63:0] b0, b1, b2, b3, b4;

   // Bit-sliced 5-bit S-box applied to all 64 columns at once.
   assign a0 = state_i[X0] ^ state_i[X4];
   assign a1 = state_i[X1];
   assign a2 = state_i[X2] ^ state_i[X1];
   assign a3 = state_i[X3];
   assign a4 = state_i[X4] ^ state_i[X3];

   assign b0 = a0 ^ (~a1 & a2);
   assign b1 = a1 ^ (~a2 & a3);
   assign b2 = a2 ^ (~a3 & a4);
   assign b3 = a3 ^ (~a4 & a0);
   assign b4 = a4 ^ (~a0 & a1);

   assign state_o[X0] = b0 ^ b4;
   assign state_o[X1] = b1 ^ b0;
   assign state_o[X2] = ~b2;
   assign state_o[X3] = b3 ^ b2;
   assign state_o[X4] = b4;
endmodule

module pl
   import ascon_pack::*;
(
   input  type_state state_i,
   output type_state state_o
);
   // Each word is XORed with two rotated copies of itself.
   for (genvar gi = 0; gi < 5; gi++) begin : g_word
      localparam int IDX = 4 - gi;
      assign state_o[IDX] = state_i[IDX]
                          ^ ror64(state_i[IDX], ROT_A[gi])
                          ^ ror64(state_i[IDX], ROT_B[gi]);
   end
endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation: one pc->ps->pl round per clock on a 320-bit state register.
module ascon_perm_iter
   import ascon_pack::*;
#(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       sel_pb_i,
   input  type_state  state_i,
   output type_state  state_o,
   output logic [3:0] round_o,
   output logic       busy_o,
   output logic       done_o
);
   // Both variants end on round 11, so they differ only in the first index.
   localparam logic [3:0] FIRST_A = 4'(NUM_ROUNDS - ROUNDS_A);
   localparam logic [3:0] FIRST_B = 4'(NUM_ROUNDS - ROUNDS_B);

   type_state    state_q, state_d;
   type_state    pc_out, ps_out, pl_out;
   type_perm_fsm fsm_q, fsm_d;
   logic         cnt_load, cnt_inc, last_round;
   logic [3:0]   round;

   round_counter u_round_counter (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .load_i     (cnt_load),
      .load_val_i (sel_pb_i ? FIRST_B : FIRST_A),
      .inc_i      (cnt_inc),
      .round_o    (round),
      .last_o     (last_round)
   );

   pc u_pc (.state_i(state_q), .round_i(round), .state_o(pc_out));
   ps u_ps (.state_i(pc_out), .state_o(ps_out));
   pl u_pl (.state_i(ps_out), .state_o(pl_out));

   // Next-state logic: accept a start from IDLE or DONE, otherwise apply one round per cycle.
   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      case (fsm_q)
         IDLE, DONE: begin
            if (start_i) begin
               fsm_d    = RUN;
               state_d  = state_i;
               cnt_load = 1'b1;
            end else begin
               fsm_d = IDLE;
            end
         end
         RUN: begin
            state_d = pl_out;
            if (last_round) begin
               fsm_d = DONE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State register and FSM; reset aborts any run in progress.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= '0;
         fsm_q   <= IDLE;
      end else begin
         state_q <= state_d;
         fsm_q   <= fsm_d;
      end
   end

   assign state_o = state_q;
   assign round_o = round;
   assign busy_o  = (fsm_q == RUN);
   assign done_o  = (fsm_q == DONE);
endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench for ascon_perm_iter: edge-counting transaction model with a table-driven Ascon round.
module tb_ascon_perm_iter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         sel = 1'b0;
   logic [319:0] st_in = '0;
   logic [319:0] st_out;
   logic [3:0]   rnd;
   logic         busy, done;

   logic         start1 = 1'b0;
   logic [319:0] st_out1;
   logic [3:0]   rnd1;
   logic         busy1, done1;

   int n_vec  = 0;
   int n_miss = 0;

   localparam logic [4:0] SBOX [0:31] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };
   localparam int R1 [0:4] = '{19, 61, 1, 10, 7};
   localparam int R2 [0:4] = '{28, 39, 6, 17, 41};

   // One round on zero state with round 11 (constant 0x4B), worked out by hand.
   localparam logic [319:0] ZERO_R11 = {
      64'h000964B00000004B, 64'h0000000096000213, 64'h53FFFFFFFFFFFF90,
      64'h12E580000000004B, 64'h0000000000000000
   };

   ascon_perm_iter u_dut (
      .clock_i (clk), .reset_i (rst), .start_i (start), .sel_pb_i (sel),
      .state_i (st_in), .state_o (st_out), .round_o (rnd),
      .busy_o  (busy), .done_o (done)
   );

   ascon_perm_iter #(.ROUNDS_A(12), .ROUNDS_B(1)) u_dut1 (
      .clock_i (clk), .reset_i (rst), .start_i (start1), .sel_pb_i (1'b1),
      .state_i ('0), .state_o (st_out1), .round_o (rnd1),
      .busy_o  (busy1), .done_o (done1)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      logic [127:0] d;
      d = {v, v} >> n;
      return d[63:0];
   endfunction

   // One Ascon round: constant into x2, S-box by table lookup per column, then diffusion.
   function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
      logic [63:0] x [5];
      logic [63:0] y [5];
      logic [4:0]  col, o;
      logic [319:0] res;
      for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
         col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
         o   = SBOX[col];
         for (int k = 0; k < 5; k++) y[k][b] = o[4 - k];
      end
      for (int k = 0; k < 5; k++)
         res[319 - 64*k -: 64] = y[k] ^ rotr(y[k], R1[k]) ^ rotr(y[k], R2[k]);
      return res;
   endfunction

   function automatic logic [319:0] model_rounds(input logic [319:0] s, input int first, input int cnt);
      logic [319:0] t;
      t = s;
      for (int r = first; r < first + cnt; r++) t = model_round(t, r);
      return t;
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] v;
      for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Transaction model: an accepted start opens an operation; outputs are a function of
   // the edges elapsed since then.
   bit           m_active = 1'b0;
   int           m_j = 0;
   int           m_n = 0;
   logic [319:0] m_init = '0;
   logic [319:0] m_hold = '0;
   logic [3:0]   m_round_hold = '0;
   bit           m_busy;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active     = 1'b0;
         m_j          = 0;
         m_n          = 0;
         m_init       = '0;
         m_hold       = '0;
         m_round_hold = '0;
      end else begin
         m_busy = m_active && (m_j < m_n);
         if (!m_busy && start) begin
            m_active = 1'b1;
            m_j      = 0;
            m_n      = sel ? 6 : 12;
            m_init   = st_in;
         end else if (m_active) begin
            m_j++;
            if (m_j > m_n) begin
               m_active     = 1'b0;
               m_hold       = model_rounds(m_init, 12 - m_n, m_n);
               m_round_hold = 4'd11;
            end
         end
      end
   end

   // Compare the DUT against the model on every falling edge outside reset.
   logic [319:0] e_state;
   logic [3:0]   e_round;
   logic         e_busy, e_done;

   always @(negedge clk) begin
      if (!rst) begin
         if (m_active) begin
            e_busy  = (m_j < m_n);
            e_done  = (m_j == m_n);
            e_round = 4'(12 - m_n + ((m_j < m_n) ? m_j : m_n - 1));
            e_state = model_rounds(m_init, 12 - m_n, m_j);
         end else begin
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_round = m_round_hold;
            e_state = m_hold;
         end
         check("busy_o", busy, e_busy);
         check("done_o", done, e_done);
         check("round_o", rnd, e_round);
         check("state_o", st_out, e_state);
      end
   end

   task automatic run_op(input bit s, input logic [319:0] v, output int lat);
      sel   = s;
      st_in = v;
      start = 1'b1;
      step();
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 30) begin
         step();
         lat++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, st_out, '0);
      check({tag, "_round"}, rnd, 4'd0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
   endtask

   initial begin
      int lat;

      #1 rst = 1'b1;
      #1 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Pin the model itself against the hand-computed single round.
      check("model_pin", model_rounds('0, 11, 1), ZERO_R11);

      // Single-round instance: round 11 only, zero input.
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check("r1_busy", busy1, 1'b1);
      check("r1_round", rnd1, 4'd11);
      step();
      check("r1_done", done1, 1'b1);
      check("r1_state", st_out1, ZERO_R11);
      step();
      check("r1_idle", done1, 1'b0);

      // p^a with the Ascon-128 IV in x0.
      run_op(1'b0, {64'h80400c0600000000, rand320()}[319:0], lat);
      check("lat_pa", lat, 12);
      step();

      // p^b.
      run_op(1'b1, rand320(), lat);
      check("lat_pb", lat, 6);
      step();

      // Starts while busy must be ignored.
      sel   = 1'b0;
      st_in = rand320();
      start = 1'b1;
      step();
      lat = 0;
      while (!done && lat < 30) begin
         start = 1'b1;
         sel   = 1'($urandom_range(0, 1));
         st_in = rand320();
         step();
         lat++;
      end
      start = 1'b0;
      check("lat_ignore", lat, 12);
      repeat (3) step();

      // Back-to-back: start in the DONE cycle of the previous run.
      run_op(1'b1, rand320(), lat);
      check("lat_b2b_1", lat, 6);
      run_op(1'b0, rand320(), lat);
      check("lat_b2b_2", lat, 12);
      run_op(1'b1, rand320(), lat);
      check("lat_b2b_3", lat, 6);
      step();

      // Abort in the middle of p^a with a mid-cycle reset, then a fresh run.
      sel   = 1'b0;
      st_in = rand320();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      rst = 1'b1;
      #1 check_reset_outputs("abort");
      step();
      rst = 1'b0;
      run_op(1'b0, rand320(), lat);
      check("lat_after_abort", lat, 12);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 2) == 0);
         sel   = 1'($urandom_range(0, 1));
         st_in = rand320();
         step();
      end
      start = 1'b0;
      repeat (15) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
